// File: rtl/sd_pkg.sv
// Shared types and constants for the Sudoku solver host driver.
package sd_pkg;

    localparam int CELLS           = 81;
    localparam int CELL_W          = 4;
    localparam int ADDR_W          = 7;
    localparam int MAX_BLANK_DEF   = 15;
    localparam int TIMEOUT_CYC_DEF = 2000;
    localparam int NO_SOL_CODE_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // True when a value is a legal filled-in Sudoku digit.
    function automatic logic is_digit(input logic [CELL_W-1:0] v);
        return (v >= 4'd1) && (v <= 4'd9);
    endfunction

    // True when a cell index addresses a real grid cell.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a < 7'd81;
    endfunction

endpackage

// File: rtl/sd_grid_ram.sv
// 81 x 4-bit puzzle store: one write port, combinational stream and readback ports.
// Contents are deliberately not reset; out-of-range reads return zero.
module sd_grid_ram import sd_pkg::*; (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CELL_W-1:0] wdata,
    input  logic [ADDR_W-1:0] stream_addr,
    output logic [CELL_W-1:0] stream_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [CELL_W-1:0] rb_data
);

    logic [CELL_W-1:0] mem_r [CELLS];

    // Single write port; writes to indices past the grid are dropped.
    always_ff @(posedge clk) begin
        if (we && addr_ok(waddr)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Stream read port feeding the outgoing cell register.
    always_comb begin
        stream_data = 4'd0;
        if (addr_ok(stream_addr)) begin
            stream_data = mem_r[stream_addr];
        end else begin
            stream_data = 4'd0;
        end
    end

    // Readback port feeding the registered rd_data output.
    always_comb begin
        rb_data = 4'd0;
        if (addr_ok(rb_addr)) begin
            rb_data = mem_r[rb_addr];
        end else begin
            rb_data = 4'd0;
        end
    end

endmodule

// File: rtl/sd_host.sv
// Host-side driver for the Sudoku solver stream: streams the 81-cell puzzle,
// collects the answers for the blank cells and writes them back in order.
module sd_host import sd_pkg::*; #(
    parameter int MAX_BLANK   = MAX_BLANK_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int NO_SOL_CODE = NO_SOL_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CELL_W-1:0] load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data,
    output logic              sd_in_valid,
    output logic [CELL_W-1:0] sd_in,
    input  logic              sd_out_valid,
    input  logic [CELL_W-1:0] sd_out,
    output logic              busy,
    output logic              done,
    output logic              no_sol,
    output logic              err,
    output logic              timeout
);

    localparam int LIST_W = $clog2(MAX_BLANK);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t            state_r;
    logic [ADDR_W-1:0] send_idx_r;
    logic [ADDR_W-1:0] blank_cnt_r;
    logic [ADDR_W-1:0] ans_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [ADDR_W-1:0] pos_r [MAX_BLANK];
    logic              first_nosol_r;

    logic              sd_in_valid_r;
    logic [CELL_W-1:0] sd_in_r;
    logic              busy_r;
    logic              done_r;
    logic              no_sol_r;
    logic              err_r;
    logic              timeout_r;
    logic [CELL_W-1:0] rd_data_r;

    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [CELL_W-1:0] wdata_s;
    logic [ADDR_W-1:0] stream_addr_s;
    logic [CELL_W-1:0] stream_data_s;
    logic [CELL_W-1:0] rb_data_s;
    logic [CELL_W-1:0] first_cell_s;
    logic [ADDR_W-1:0] ans_idx_s;
    logic [ADDR_W-1:0] ans_pos_s;
    logic              ans_in_list_s;
    logic              ans_nosol_s;
    logic              ans_bad_s;

    sd_grid_ram u_ram (
        .clk         (clk),
        .we          (we_s),
        .waddr       (waddr_s),
        .wdata       (wdata_s),
        .stream_addr (stream_addr_s),
        .stream_data (stream_data_s),
        .rb_addr     (rd_addr),
        .rb_data     (rb_data_s)
    );

    assign sd_in_valid = sd_in_valid_r;
    assign sd_in       = sd_in_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign no_sol      = no_sol_r;
    assign err         = err_r;
    assign timeout     = timeout_r;
    assign rd_data     = rd_data_r;

    // Stream address looks one cell ahead of the cell currently on sd_in.
    always_comb begin
        stream_addr_s = 7'd0;
        if (state_r == ST_SEND) begin
            stream_addr_s = send_idx_r + 7'd1;
        end else begin
            stream_addr_s = 7'd0;
        end
    end

    // Cell 0 for the start edge, forwarding a same-cycle load of cell 0.
    always_comb begin
        first_cell_s = stream_data_s;
        if (load_en && (load_addr == 7'd0)) begin
            first_cell_s = load_data;
        end else begin
            first_cell_s = stream_data_s;
        end
    end

    // Classify the answer presented this cycle and find its target cell.
    always_comb begin
        ans_idx_s = 7'd0;
        ans_pos_s = 7'd0;
        if (state_r == ST_RECV) begin
            ans_idx_s = ans_cnt_r;
        end else begin
            ans_idx_s = 7'd0;
        end
        ans_in_list_s = (ans_idx_s < blank_cnt_r) && (ans_idx_s < ADDR_W'(MAX_BLANK));
        if (ans_idx_s < ADDR_W'(MAX_BLANK)) begin
            ans_pos_s = pos_r[ans_idx_s[LIST_W-1:0]];
        end else begin
            ans_pos_s = 7'd0;
        end
        ans_nosol_s = (ans_idx_s == 7'd0) && (sd_out == CELL_W'(NO_SOL_CODE));
        ans_bad_s   = !is_digit(sd_out) && !ans_nosol_s;
    end

    // RAM write port: loads while idle, answer write-back while receiving.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = load_addr;
        wdata_s = load_data;
        case (state_r)
            ST_IDLE: begin
                if (load_en) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_WAIT, ST_RECV: begin
                waddr_s = ans_pos_s;
                wdata_s = sd_out;
                if (sd_out_valid && ans_in_list_s && is_digit(sd_out)) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Control FSM with counters, blank position list and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            send_idx_r    <= 7'd0;
            blank_cnt_r   <= 7'd0;
            ans_cnt_r     <= 7'd0;
            tmo_cnt_r     <= '0;
            first_nosol_r <= 1'b0;
            sd_in_valid_r <= 1'b0;
            sd_in_r       <= 4'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            no_sol_r      <= 1'b0;
            err_r         <= 1'b0;
            timeout_r     <= 1'b0;
            rd_data_r     <= 4'd0;
            for (int i = 0; i < MAX_BLANK; i++) begin
                pos_r[i] <= 7'd0;
            end
        end else begin
            done_r    <= 1'b0;
            rd_data_r <= rb_data_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_SEND;
                        busy_r        <= 1'b1;
                        no_sol_r      <= 1'b0;
                        err_r         <= 1'b0;
                        timeout_r     <= 1'b0;
                        sd_in_valid_r <= 1'b1;
                        sd_in_r       <= first_cell_s;
                        send_idx_r    <= 7'd0;
                        blank_cnt_r   <= 7'd0;
                        ans_cnt_r     <= 7'd0;
                        tmo_cnt_r     <= '0;
                        first_nosol_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (sd_in_r == 4'd0) begin
                        blank_cnt_r <= blank_cnt_r + 7'd1;
                        if (blank_cnt_r < ADDR_W'(MAX_BLANK)) begin
                            pos_r[blank_cnt_r[LIST_W-1:0]] <= send_idx_r;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    if (send_idx_r == 7'd80) begin
                        sd_in_valid_r <= 1'b0;
                        sd_in_r       <= 4'd0;
                        tmo_cnt_r     <= TMO_W'(1);
                        state_r       <= ST_WAIT;
                    end else begin
                        send_idx_r <= send_idx_r + 7'd1;
                        sd_in_r    <= stream_data_s;
                    end
                end
                ST_WAIT: begin
                    if (sd_out_valid) begin
                        ans_cnt_r <= 7'd1;
                        if (ans_nosol_s) begin
                            first_nosol_r <= 1'b1;
                        end
                        if (ans_bad_s) begin
                            err_r <= 1'b1;
                        end
                        state_r <= ST_RECV;
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_RECV: begin
                    if (sd_out_valid) begin
                        if (ans_cnt_r != 7'd127) begin
                            ans_cnt_r <= ans_cnt_r + 7'd1;
                        end
                        if (ans_bad_s) begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                        if ((ans_cnt_r == 7'd1) && first_nosol_r) begin
                            no_sol_r <= 1'b1;
                        end else if (first_nosol_r || (ans_cnt_r != blank_cnt_r)) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r        <= 1'b0;
                    sd_in_valid_r <= 1'b0;
                    sd_in_r       <= 4'd0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_host.sv
// Directed bench for sd_host: stream shape, write-back, no-solution, timeout,
// error cases, overflow of the blank list and mid-solve reset.
module tb_sd_host;

    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [6:0] load_addr;
    logic [3:0] load_data;
    logic       start;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       sd_in_valid;
    logic [3:0] sd_in;
    logic       sd_out_valid;
    logic [3:0] sd_out;
    logic       busy;
    logic       done;
    logic       no_sol;
    logic       err;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    logic [3:0] resp [16];

    always #5 clk = ~clk;

    sd_host dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sd_in_valid  (sd_in_valid),
        .sd_in        (sd_in),
        .sd_out_valid (sd_out_valid),
        .sd_out       (sd_out),
        .busy         (busy),
        .done         (done),
        .no_sol       (no_sol),
        .err          (err),
        .timeout      (timeout)
    );

    // Solved grid: a standard shifted-row valid Sudoku.
    function automatic logic [3:0] sol_val(input int i);
        int r;
        int c;
        r = i / 9;
        c = i % 9;
        return 4'((r * 3 + r / 3 + c) % 9 + 1);
    endfunction

    // Puzzle with blanks at cells 0,5,10,... (first nb of them).
    function automatic logic [3:0] puz_val(input int i, input int nb);
        if ((i % 5) == 0 && (i / 5) < nb) return 4'd0;
        else return sol_val(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_puzzle(input int nb);
        for (int i = 0; i < 81; i++) begin
            load_en   = 1'b1;
            load_addr = 7'(i);
            load_data = puz_val(i, nb);
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic set_resp();
        for (int j = 0; j < 16; j++) resp[j] = sol_val(j * 5);
    endtask

    // Pulse start and stop in the first WAIT cycle (one after the last cell).
    task automatic start_solve();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (81) tick();
    endtask

    task automatic respond(input int n);
        for (int j = 0; j < n; j++) begin
            sd_out_valid = 1'b1;
            sd_out       = resp[j];
            tick();
        end
        sd_out_valid = 1'b0;
        sd_out       = 4'd0;
    endtask

    task automatic wait_done(output int ndone);
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (busy === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({sd_in_valid, sd_in, busy, done} !== 7'd0) begin
            bad++;
            $display("FAIL reset_stream: got %b want 0", {sd_in_valid, sd_in, busy, done});
        end
        total++;
        if ({no_sol, err, timeout, rd_data} !== 7'd0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0", {no_sol, err, timeout, rd_data});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_solve();
        int nd;
        load_puzzle(15);
        set_resp();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 81; k++) begin
            total++;
            if (sd_in_valid !== 1'b1 || sd_in !== puz_val(k, 15) || busy !== 1'b1) begin
                bad++;
                $display("FAIL stream_cell%0d: got v=%b d=%0d b=%b want v=1 d=%0d b=1",
                         k, sd_in_valid, sd_in, busy, puz_val(k, 15));
            end
            if (k < 80) tick();
        end
        tick();
        total++;
        if (sd_in_valid !== 1'b0 || sd_in !== 4'd0) begin
            bad++;
            $display("FAIL stream_end: got v=%b d=%0d want v=0 d=0", sd_in_valid, sd_in);
        end
        respond(15);
        wait_done(nd);
        total++;
        if (nd !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL solve_done: got pulses=%0d busy=%b want 1 0", nd, busy);
        end
        total++;
        if ({no_sol, err, timeout} !== 3'b000) begin
            bad++;
            $display("FAIL solve_flags: got %b want 000", {no_sol, err, timeout});
        end
        for (int i = 0; i < 81; i++) begin
            rd_addr = 7'(i);
            tick();
            total++;
            if (rd_data !== sol_val(i)) begin
                bad++;
                $display("FAIL solve_cell%0d: got %0d want %0d", i, rd_data, sol_val(i));
            end
        end
    endtask

    task automatic test_no_sol();
        int nd;
        load_puzzle(15);
        load_en = 1'b1; load_addr = 7'd0; load_data = 4'd7;
        tick();
        load_en = 1'b1; load_addr = 7'd0; load_data = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_en = 1'b0;
        total++;
        if (sd_in_valid !== 1'b1 || sd_in !== 4'd0) begin
            bad++;
            $display("FAIL start_load_fwd: got v=%b d=%0d want v=1 d=0", sd_in_valid, sd_in);
        end
        repeat (81) tick();
        resp[0] = 4'd10;
        respond(1);
        wait_done(nd);
        total++;
        if (nd !== 1 || {no_sol, err, timeout} !== 3'b100) begin
            bad++;
            $display("FAIL nosol_flags: got pulses=%0d flags=%b want 1 100", nd, {no_sol, err, timeout});
        end
        for (int i = 0; i < 81; i++) begin
            rd_addr = 7'(i);
            tick();
            total++;
            if (rd_data !== puz_val(i, 15)) begin
                bad++;
                $display("FAIL nosol_cell%0d: got %0d want %0d", i, rd_data, puz_val(i, 15));
            end
        end
    endtask

    task automatic test_timeout();
        int first;
        logic done_at;
        first = 0;
        done_at = 1'b0;
        load_puzzle(15);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (80) tick();
        for (int c = 1; c <= TMO + 5; c++) begin
            tick();
            if (timeout === 1'b1) begin
                first   = c;
                done_at = done;
                break;
            end
        end
        total++;
        if (first !== TMO || done_at !== 1'b1) begin
            bad++;
            $display("FAIL timeout_cycle: got c=%0d done=%b want c=%0d done=1", first, done_at, TMO);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_after: got busy=%b done=%b to=%b want 0 0 1", busy, done, timeout);
        end
    endtask

    task automatic test_err_short();
        int nd;
        logic [3:0] exp;
        load_puzzle(15);
        set_resp();
        start_solve();
        respond(14);
        wait_done(nd);
        total++;
        if (nd !== 1 || {no_sol, err, timeout} !== 3'b010) begin
            bad++;
            $display("FAIL short_flags: got pulses=%0d flags=%b want 1 010", nd, {no_sol, err, timeout});
        end
        for (int i = 0; i < 81; i++) begin
            exp = (i == 70) ? 4'd0 : sol_val(i);
            rd_addr = 7'(i);
            tick();
            total++;
            if (rd_data !== exp) begin
                bad++;
                $display("FAIL short_cell%0d: got %0d want %0d", i, rd_data, exp);
            end
        end
    endtask

    task automatic test_err_zero();
        int nd;
        logic [3:0] exp;
        load_puzzle(15);
        set_resp();
        resp[3] = 4'd0;
        start_solve();
        respond(15);
        wait_done(nd);
        total++;
        if (nd !== 1 || {no_sol, err, timeout} !== 3'b010) begin
            bad++;
            $display("FAIL zero_flags: got pulses=%0d flags=%b want 1 010", nd, {no_sol, err, timeout});
        end
        for (int i = 0; i < 81; i++) begin
            exp = (i == 15) ? 4'd0 : sol_val(i);
            rd_addr = 7'(i);
            tick();
            total++;
            if (rd_data !== exp) begin
                bad++;
                $display("FAIL zero_cell%0d: got %0d want %0d", i, rd_data, exp);
            end
        end
    endtask

    task automatic test_overflow();
        int nd;
        logic [3:0] exp;
        load_puzzle(16);
        set_resp();
        start_solve();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_err_early: got %b want 1", err);
        end
        respond(16);
        wait_done(nd);
        total++;
        if (nd !== 1 || {no_sol, err, timeout} !== 3'b010) begin
            bad++;
            $display("FAIL ovf_flags: got pulses=%0d flags=%b want 1 010", nd, {no_sol, err, timeout});
        end
        for (int i = 0; i < 81; i++) begin
            exp = (i == 75) ? 4'd0 : sol_val(i);
            rd_addr = 7'(i);
            tick();
            total++;
            if (rd_data !== exp) begin
                bad++;
                $display("FAIL ovf_cell%0d: got %0d want %0d", i, rd_data, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_puzzle(15);
        start = 1'b1;
        tick();
        load_en = 1'b1; load_addr = 7'd0; load_data = 4'd9;
        repeat (39) tick();
        start = 1'b0;
        load_en = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if ({sd_in_valid, sd_in, busy, done, no_sol, err, timeout, rd_data} !== 14'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got %b want 0",
                     {sd_in_valid, sd_in, busy, done, no_sol, err, timeout, rd_data});
        end
        rst = 1'b0;
        sd_out_valid = 1'b1;
        sd_out = 4'd5;
        repeat (3) tick();
        sd_out_valid = 1'b0;
        sd_out = 4'd0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        rd_addr = 7'd0;
        tick();
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL midrst_cell0: got %0d want 0", rd_data);
        end
        rd_addr = 7'd1;
        tick();
        total++;
        if (rd_data !== sol_val(1)) begin
            bad++;
            $display("FAIL midrst_cell1: got %0d want %0d", rd_data, sol_val(1));
        end
    endtask

    initial begin
        rst = 1'b1;
        load_en = 1'b0;
        load_addr = 7'd0;
        load_data = 4'd0;
        start = 1'b0;
        rd_addr = 7'd0;
        sd_out_valid = 1'b0;
        sd_out = 4'd0;
        test_reset();
        test_solve();
        test_no_sol();
        test_timeout();
        test_err_short();
        test_err_zero();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_host.md
Name: sd_host

Overview:
- Host-side driver for the Sudoku solver (SD) stream interface; the transmitting/collecting end of the solver's in_valid/in -> out_valid/out protocol.
- Holds an 81-cell puzzle RAM (row-major, 0 = blank) loaded over a parallel write port.
- On start: streams the 81 nibbles to the solver, collects the returned blank answers, writes them back into the blank cells in row-major order, and reports status.
- Sits between a controller/CPU wrapper and SD; also reused as a synthesizable self-test front end.

Parameters:
- MAX_BLANK, 15, max blank cells recorded in the position list.
- TIMEOUT_CYC, 2000, max cycles from last sent cell to first sd_out_valid.
- NO_SOL_CODE, 10, solver output value meaning "no solution".

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data into RAM[load_addr]; honoured only when busy=0
- load_addr  in  7  cell index 0..80; values >80 ignored
- load_data  in  4  cell value 0..9
- start  in  1  begin a solve; honoured only in IDLE
- rd_addr  in  7  readback cell index
- rd_data  out  4  RAM[rd_addr], registered, 1-cycle latency
- sd_in_valid  out  1  to solver in_valid
- sd_in  out  4  to solver in
- sd_out_valid  in  1  from solver out_valid
- sd_out  in  4  from solver out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a solve finishes
- no_sol  out  1  solver reported no solution; held until next accepted start
- err  out  1  protocol/overflow error; held until next accepted start
- timeout  out  1  solver did not answer; held until next accepted start

Behaviour:
- Reset: state=IDLE; sd_in_valid, sd_in, busy, done, no_sol, err, timeout, rd_data = 0; counters and blank list cleared. RAM contents are not reset. Reset mid-operation aborts immediately to IDLE; a solver response arriving afterwards is ignored in IDLE.
- All outputs are registered.
- FSM IDLE -> SEND -> WAIT -> RECV -> DONE -> IDLE.
- IDLE: start=1 clears no_sol/err/timeout and moves to SEND. load_en in the same cycle as start is written first; it is visible in the stream.
- SEND: cell k (0..80) is driven on sd_in with sd_in_valid=1 in cycle t+1+k, where t is the start cycle; 81 contiguous valid cycles, no gaps.
  - Each zero cell increments blank_cnt (7 bits).
  - The first MAX_BLANK zero positions are stored in a position list in order.
  - blank_cnt > MAX_BLANK sets err; the solve still continues.
  - After cell 80: sd_in_valid=0, sd_in=0, go to WAIT.
- WAIT: timeout counter increments each cycle.
  - Reaching TIMEOUT_CYC without sd_out_valid: set timeout, go to DONE.
  - sd_out_valid=1: go to RECV, handling that cycle's data as answer 0.
- RECV: answer j is written to RAM[pos[j]] for j < min(blank_cnt, MAX_BLANK).
  - Answers not in 1..9 set err and are not written.
  - Run terminates on the first cycle with sd_out_valid=0, then go to DONE.
  - Run length 1 with value NO_SOL_CODE: set no_sol, no RAM write, err unchanged.
  - Otherwise run length != blank_cnt sets err; answers beyond the list are ignored.
- DONE: done=1 for exactly this cycle, busy=1, then IDLE.
- busy=1: load_en and start ignored. rd_data stays valid in all states and shows in-progress writes.
- blank_cnt=0 is legal: expect a zero-length response, i.e. timeout.

Decomposition:
- Package sd_pkg: state enum, CELLS=81, CELL_W=4, ADDR_W=7, NO_SOL_CODE default.
- One sub-module, sd_grid_ram: 81x4, one write port, two read ports (stream and readback), no reset.
- FSM, counters and position list stay in sd_host.

Test Plan:
- Load a 15-blank valid puzzle, start -> sd_in_valid high for exactly 81 cycles starting at t+1 with values equal to RAM. Model returns 15 answers -> RAM blanks filled correctly, done pulse once, no_sol=err=timeout=0.
- Same puzzle, model returns a single cycle of out=10 -> no_sol=1, err=0, RAM unchanged, done pulse.
- Model never responds -> timeout=1 exactly TIMEOUT_CYC cycles after the last sent cell, done pulse, busy falls the next cycle.
- Model returns 14 answers, or one answer equal to 0 -> err=1. Valid answers are still written; the zero is not written.
- 16-blank puzzle -> err=1, first 15 blanks filled, 16th remains 0.
- Assert rst on the 40th SEND cycle -> next cycle IDLE, all outputs 0. start and load_en while busy are ignored (RAM unchanged).
